// File: rtl/ram_bus_pkg.sv
// Shared definitions for the picorv32-to-word-RAM bridge.
// Holds the bridge FSM state encoding and the data returned on out-of-window accesses.
// No logic; imported by ram_bus_bridge and ram_bus_stat.
package ram_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAPT  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic [31:0] FAULT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ram_bus_stat.sv
// Completed-transaction counters: data reads, writes and instruction fetches.
// Latency: counters update on the clock edge that ends the done cycle.
// Backpressure: none; sampling only, the bridge never waits on this block.
module ram_bus_stat
  import ram_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic        is_write,
  input  logic        is_instr,
  output logic [31:0] stat_rd,
  output logic [31:0] stat_wr,
  output logic [31:0] stat_if
);

  logic [31:0] rd_q, wr_q, if_q;

  // Count each completed transaction into exactly one bucket; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 32'd0;
      wr_q <= 32'd0;
      if_q <= 32'd0;
    end else if (done) begin
      if (is_write)      wr_q <= wr_q + 32'd1;
      else if (is_instr) if_q <= if_q + 32'd1;
      else               rd_q <= rd_q + 32'd1;
    end
  end

  assign stat_rd = rd_q;
  assign stat_wr = wr_q;
  assign stat_if = if_q;

endmodule

// File: rtl/ram_bus_bridge.sv
// Bridges picorv32 mem_valid/mem_ready to a 1-cycle registered single-port word RAM; flags out-of-window accesses.
// Latency: 4+WAIT_STATES cycles in window, 2 cycles for a fault; mem_ready is a one-cycle registered pulse.
// Backpressure: CPU holds mem_valid until mem_ready; one transaction in flight. RAM_BUS_STAT_EN adds stat counters.
module ram_bus_bridge
  import ram_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = 16,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  ram_ce,
  output logic [3:0]            ram_wr,
  output logic [31:0]           ram_d,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [31:0]           ram_q,
  output logic                  fault,
  output logic [31:0]           fault_addr
`ifdef RAM_BUS_STAT_EN
  ,
  output logic [31:0]           stat_rd,
  output logic [31:0]           stat_wr,
  output logic [31:0]           stat_if
`endif
);

  localparam logic [31:0] WIN_MASK = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);
  localparam logic [3:0]  WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  ram_ce_q, ram_ce_d;
  logic [3:0]            ram_wr_q, ram_wr_d;
  logic [31:0]           ram_d_q, ram_d_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           hold_q, hold_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  fault_q, fault_d;
  logic [31:0]           fault_addr_q, fault_addr_d;
  logic                  is_wr_q, is_wr_d;
  logic                  is_if_q, is_if_d;
  logic                  in_win;

  assign in_win = (mem_addr & WIN_MASK) == BASE_ADDR;

  // Next-state and registered-output decode; every _d defaults to hold except the pulses.
  always_comb begin
    state_d      = state_q;
    mem_ready_d  = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    ram_ce_d     = 1'b0;
    ram_wr_d     = 4'b0000;
    ram_d_d      = ram_d_q;
    ram_addr_d   = ram_addr_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    is_wr_d      = is_wr_q;
    is_if_d      = is_if_q;
    unique case (state_q)
      IDLE: begin
        // mem_ready_q guard stops a still-high mem_valid from re-triggering right after a response.
        if (mem_valid && !mem_ready_q) begin
          if (in_win) begin
            ram_ce_d   = 1'b1;
            ram_wr_d   = mem_wstrb;
            ram_d_d    = mem_wdata;
            ram_addr_d = mem_addr[ADDR_WIDTH+1:2];
            is_wr_d    = |mem_wstrb;
            is_if_d    = mem_instr;
            state_d    = ISSUE;
          end else begin
            // Fault response is registered on entry so it is visible during the FAULT cycle.
            mem_ready_d = 1'b1;
            mem_rdata_d = FAULT_DATA;
            fault_d     = 1'b1;
            if (!fault_q) fault_addr_d = mem_addr;
            state_d     = FAULT;
          end
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        hold_d = ram_q;
        if (WAIT_STATES > 0) begin
          cnt_d   = WS_LOAD;
          state_d = WAIT;
        end else begin
          mem_ready_d = 1'b1;
          mem_rdata_d = is_wr_q ? 32'h0 : ram_q;
          state_d     = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_ready_d = 1'b1;
          mem_rdata_d = is_wr_q ? 32'h0 : hold_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; RAM-side outputs are registered so the RAM sees clean timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_ready_q  <= 1'b0;
      mem_rdata_q  <= 32'h0;
      ram_ce_q     <= 1'b0;
      ram_wr_q     <= 4'b0000;
      ram_d_q      <= 32'h0;
      ram_addr_q   <= '0;
      hold_q       <= 32'h0;
      cnt_q        <= 4'd0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      is_wr_q      <= 1'b0;
      is_if_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_ready_q  <= mem_ready_d;
      mem_rdata_q  <= mem_rdata_d;
      ram_ce_q     <= ram_ce_d;
      ram_wr_q     <= ram_wr_d;
      ram_d_q      <= ram_d_d;
      ram_addr_q   <= ram_addr_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      is_wr_q      <= is_wr_d;
      is_if_q      <= is_if_d;
    end
  end

  assign mem_ready  = mem_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign ram_ce     = ram_ce_q;
  assign ram_wr     = ram_wr_q;
  assign ram_d      = ram_d_q;
  assign ram_addr   = ram_addr_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

`ifdef RAM_BUS_STAT_EN
  // Faults never reach RESP, so they are excluded from the counters by construction.
  ram_bus_stat u_stat (
    .clk      (clk),
    .rst      (rst),
    .done     (state_q == RESP),
    .is_write (is_wr_q),
    .is_instr (is_if_q),
    .stat_rd  (stat_rd),
    .stat_wr  (stat_wr),
    .stat_if  (stat_if)
  );
`else
  logic stat_unused;
  assign stat_unused = is_if_q;
`endif

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Directed bench for ram_bus_bridge: u0 has no wait states, u1 has three; each drives its own RAM model.
// Latency is counted with the IDLE cycle that first sees mem_valid as cycle 1.
// Stat counters are checked only when RAM_BUS_STAT_EN is defined.
module tb_ram_bus_bridge;
  import ram_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid [2];
  logic        mem_instr [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic        mem_ready [2];
  logic [31:0] mem_rdata [2];
  logic        ram_ce    [2];
  logic [3:0]  ram_wr    [2];
  logic [31:0] ram_d     [2];
  logic [15:0] ram_addr  [2];
  logic [31:0] ram_q     [2];
  logic        fault     [2];
  logic [31:0] fault_addr[2];
`ifdef RAM_BUS_STAT_EN
  logic [31:0] stat_rd [2];
  logic [31:0] stat_wr [2];
  logic [31:0] stat_if [2];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_bus_bridge #(.BASE_ADDR(32'h0), .ADDR_WIDTH(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
    .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]), .ram_ce(ram_ce[0]),
    .ram_wr(ram_wr[0]), .ram_d(ram_d[0]), .ram_addr(ram_addr[0]), .ram_q(ram_q[0]),
    .fault(fault[0]), .fault_addr(fault_addr[0])
`ifdef RAM_BUS_STAT_EN
    , .stat_rd(stat_rd[0]), .stat_wr(stat_wr[0]), .stat_if(stat_if[0])
`endif
  );

  ram_bus_bridge #(.BASE_ADDR(32'h0), .ADDR_WIDTH(16), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
    .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]), .ram_ce(ram_ce[1]),
    .ram_wr(ram_wr[1]), .ram_d(ram_d[1]), .ram_addr(ram_addr[1]), .ram_q(ram_q[1]),
    .fault(fault[1]), .fault_addr(fault_addr[1])
`ifdef RAM_BUS_STAT_EN
    , .stat_rd(stat_rd[1]), .stat_wr(stat_wr[1]), .stat_if(stat_if[1])
`endif
  );

  // Single-port word RAM with byte enables and a one-cycle registered read.
  logic [31:0] ram_mem [2][64];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_ce[k]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wr[k][b]) ram_mem[k][ram_addr[k][5:0]][8*b +: 8] <= ram_d[k][8*b +: 8];
        ram_q[k] <= ram_mem[k][ram_addr[k][5:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; lat is the cycle (IDLE = 1) in which mem_ready is seen, -1 on timeout.
  task automatic xfer(input int k, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic ins,
                      output logic [31:0] rd, output int lat, output logic ce_seen);
    int   n;
    logic got;
    @(negedge clk);
    mem_valid[k] = 1'b1; mem_addr[k] = a; mem_wdata[k] = wd;
    mem_wstrb[k] = st;   mem_instr[k] = ins;
    n = 0; got = 1'b0; ce_seen = 1'b0; rd = 32'h0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ram_ce[k]) ce_seen = 1'b1;
      if (mem_ready[k]) begin
        got = 1'b1;
        rd  = mem_rdata[k];
      end
    end
    mem_valid[k] = 1'b0; mem_wstrb[k] = 4'h0; mem_instr[k] = 1'b0;
    lat = got ? n + 1 : -1;
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(mem_ready[k]), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat;
  logic        ce;

  initial begin
    for (int k = 0; k < 2; k++) begin
      mem_valid[k] = 1'b0; mem_instr[k] = 1'b0; mem_addr[k] = 32'h0;
      mem_wdata[k] = 32'h0; mem_wstrb[k] = 4'h0; ram_q[k] = 32'h0;
      for (int w = 0; w < 64; w++) ram_mem[k][w] = 32'h0;
    end
    do_reset();

    // Reset state
    chk("rst_ready", 32'(mem_ready[0]), 32'd0);
    chk("rst_ce",    32'(ram_ce[0]),    32'd0);
    chk("rst_wr",    32'(ram_wr[0]),    32'd0);
    chk("rst_fault", 32'(fault[0]),     32'd0);
    chk("rst_faddr", fault_addr[0],     32'h0);
    chk("rst_rdata", mem_rdata[0],      32'h0);
    chk("rst_raddr", 32'(ram_addr[0]),  32'h0);

    // 1: full-word write then read at 0x10
    xfer(0, 32'h10, 32'h1122_3344, 4'hF, 1'b0, rd, lat, ce);
    chk("t1_wr_lat",   lat, 32'd4);
    chk("t1_wr_rdata", rd,  32'h0);
    xfer(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    chk("t1_rd_lat",   lat, 32'd4);
    chk("t1_rd_data",  rd,  32'h1122_3344);
    chk("t1_ram_addr", 32'(ram_addr[0]), 32'd4);

    // 2: byte-lane 1 write merges into existing word
    xfer(0, 32'h10, 32'h0000_AA00, 4'b0010, 1'b0, rd, lat, ce);
    chk("t2_wr_lat", lat, 32'd4);
    xfer(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    chk("t2_rd_data", rd, 32'h1122_AA44);

    // 3: three wait states
    xfer(1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat, ce);
    chk("t3_wr_lat", lat, 32'd7);
    xfer(1, 32'h20, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    chk("t3_rd_lat",  lat, 32'd7);
    chk("t3_rd_data", rd,  32'hCAFE_F00D);

    // Last word of the window is still in range
    xfer(0, 32'h0003_FFFC, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    chk("win_top_lat",   lat, 32'd4);
    chk("win_top_fault", 32'(fault[0]), 32'd0);

    // 5: reset during CAPT
    @(negedge clk);
    mem_valid[0] = 1'b1; mem_addr[0] = 32'h10; mem_wstrb[0] = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("t5_in_capt", 32'(u0.state_q), 32'(CAPT));
    rst = 1'b1; mem_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_ready", 32'(mem_ready[0]), 32'd0);
    chk("t5_rst_state", 32'(u0.state_q), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_no_ready", 32'(mem_ready[0]), 32'd0);
    xfer(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    chk("t5_rd_lat",  lat, 32'd4);
    chk("t5_rd_data", rd,  32'h1122_AA44);

    // 4: out-of-window read, then a second fault
    xfer(0, 32'h0004_0000, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    chk("t4_lat",   lat, 32'd2);
    chk("t4_rdata", rd,  32'hDEAD_BEEF);
    chk("t4_no_ce", 32'(ce), 32'd0);
    chk("t4_fault", 32'(fault[0]), 32'd1);
    chk("t4_faddr", fault_addr[0], 32'h0004_0000);
    xfer(0, 32'h8000_0000, 32'h5555_5555, 4'hF, 1'b0, rd, lat, ce);
    chk("t4b_lat",   lat, 32'd2);
    chk("t4b_faddr", fault_addr[0], 32'h0004_0000);

    // 6: counters from a clean reset
    do_reset();
    chk("t6_fault_clr", 32'(fault[0]), 32'd0);
    xfer(0, 32'h0, 32'h0, 4'h0, 1'b1, rd, lat, ce);
    xfer(0, 32'h4, 32'h0, 4'h0, 1'b1, rd, lat, ce);
    xfer(0, 32'h8, 32'h0, 4'h0, 1'b1, rd, lat, ce);
    xfer(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    chk("t6_load_data", rd, 32'h1122_AA44);
    xfer(0, 32'h14, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    xfer(0, 32'h18, 32'h0BAD_F00D, 4'hF, 1'b0, rd, lat, ce);
    xfer(0, 32'h0010_0000, 32'h0, 4'h0, 1'b0, rd, lat, ce);
    chk("t6_fault_lat", lat, 32'd2);
`ifdef RAM_BUS_STAT_EN
    chk("t6_stat_if", stat_if[0], 32'd3);
    chk("t6_stat_rd", stat_rd[0], 32'd2);
    chk("t6_stat_wr", stat_wr[0], 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
